mem_access_unit: RTL and testbench

- MEM-stage data-memory controller. Consumes the EX/MEM pipeline register outputs (address, store data, read/write strobes, func3).
- Drives a word-wide data-memory bus with a req/ack handshake and variable latency.
- Returns sign/zero-extended load data to the MEM/WB register.
- Asserts BUSY_WAIT to stall the pipeline while an access is outstanding.

---
 rtl/mem_access_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage data-memory controller. Takes an EX/MEM load/store,
//            runs one req/ack transaction on a word-wide data bus, stalls the
//            pipeline with BUSY_WAIT while it is outstanding and returns
//            sign/zero-extended load data for one COMPLETE cycle.
// Ports    : CLK, RST (async, active-high)
//            ADDRESS, WRITE_DATA, MEM_READ, MEM_WRITE, FUNC3  - request
//            BUSY_WAIT, LOAD_DATA, ACCESS_FAULT              - pipeline side
//            DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BYTE_EN,
//            DM_RDATA, DM_ACK                                - memory bus
// Params   : ACK_TIMEOUT - ACCESS cycles allowed before a timeout fault (1..255)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  output logic        BUSY_WAIT,
  output logic [31:0] LOAD_DATA,
  output logic        ACCESS_FAULT,
  output logic        DM_REQ,
  output logic        DM_WE,
  output logic [31:0] DM_ADDR,
  output logic [31:0] DM_WDATA,
  output logic [3:0]  DM_BYTE_EN,
  input  logic [31:0] DM_RDATA,
  input  logic        DM_ACK
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  // Counter value seen in the last ACCESS cycle before giving up.
  localparam logic [7:0] c_CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      r_state;
  logic [2:0]  r_func3;
  logic [1:0]  r_addr_lo;
  logic        r_is_load;
  logic [31:0] r_buf;
  logic [7:0]  r_cnt;
  logic        r_fault;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_illegal;
  logic        w_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Request decode (only meaningful while IDLE)
  always_comb begin
    w_is_load  = MEM_READ & ~MEM_WRITE;
    w_is_store = MEM_WRITE & ~MEM_READ;
    case (FUNC3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = w_is_load;   // unsigned forms are load-only
      default:                w_f3_ok = 1'b0;
    endcase
    w_misalign = ((FUNC3[1:0] == 2'b01) && ADDRESS[0]) ||
                 ((FUNC3[1:0] == 2'b10) && (ADDRESS[1:0] != 2'b00));
    // Both strobes high is not a valid request but is still reported.
    w_illegal  = (MEM_READ | MEM_WRITE) &
                 (~(w_is_load | w_is_store) | ~w_f3_ok | w_misalign);
    w_start    = (w_is_load | w_is_store) & w_f3_ok & ~w_misalign;
  end

  // Lane placement for stores; loads always fetch the whole word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WRITE_DATA;
    if (w_is_store) begin
      case (FUNC3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << ADDRESS[1:0];
          w_wdata = {4{WRITE_DATA[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {ADDRESS[1], 1'b0};
          w_wdata = {2{WRITE_DATA[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = WRITE_DATA;
        end
      endcase
    end
  end

  // Load extraction from the buffered word
  always_comb begin
    case (r_addr_lo)
      2'd0:    w_byte = r_buf[7:0];
      2'd1:    w_byte = r_buf[15:8];
      2'd2:    w_byte = r_buf[23:16];
      default: w_byte = r_buf[31:24];
    endcase
    w_half = r_addr_lo[1] ? r_buf[31:16] : r_buf[15:0];
    case (r_func3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = r_buf;
    endcase
  end

  always_comb begin
    BUSY_WAIT    = ((r_state == ST_IDLE) && w_start) || (r_state == ST_ACCESS);
    ACCESS_FAULT = ((r_state == ST_IDLE) && w_illegal) ||
                   ((r_state == ST_COMPLETE) && r_fault);
    LOAD_DATA    = ((r_state == ST_COMPLETE) && r_is_load) ? w_ext : 32'd0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_func3    <= 3'd0;
      r_addr_lo  <= 2'd0;
      r_is_load  <= 1'b0;
      r_buf      <= 32'd0;
      r_cnt      <= 8'd0;
      r_fault    <= 1'b0;
      DM_REQ     <= 1'b0;
      DM_WE      <= 1'b0;
      DM_ADDR    <= 32'd0;
      DM_WDATA   <= 32'd0;
      DM_BYTE_EN <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_fault <= 1'b0;
          if (w_start) begin
            r_state    <= ST_ACCESS;
            DM_REQ     <= 1'b1;
            DM_WE      <= w_is_store;
            DM_ADDR    <= {ADDRESS[31:2], 2'b00};
            DM_WDATA   <= w_wdata;
            DM_BYTE_EN <= w_be;
            r_func3    <= FUNC3;
            r_addr_lo  <= ADDRESS[1:0];
            r_is_load  <= w_is_load;
            r_cnt      <= 8'd0;
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 8'd1;
          // An ack in the final allowed cycle still completes normally.
          if (DM_ACK) begin
            if (r_is_load) r_buf <= DM_RDATA;
            DM_REQ  <= 1'b0;
            r_state <= ST_COMPLETE;
          end else if (r_cnt == c_CNT_LAST) begin
            DM_REQ  <= 1'b0;
            r_fault <= 1'b1;
            r_buf   <= 32'd0;
            r_state <= ST_COMPLETE;
          end
        end
        ST_COMPLETE: begin
          r_fault <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit: directed vector table,
//            hand-written multi-cycle sequences (reset mid-access,
//            back-to-back) and randomized requests against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ADDRESS, WRITE_DATA, DM_RDATA;
  logic        MEM_READ, MEM_WRITE, DM_ACK;
  logic [2:0]  FUNC3;
  logic        BUSY_WAIT, ACCESS_FAULT, DM_REQ, DM_WE;
  logic [31:0] LOAD_DATA, DM_ADDR, DM_WDATA;
  logic [3:0]  DM_BYTE_EN;

  mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .FUNC3(FUNC3),
    .BUSY_WAIT(BUSY_WAIT), .LOAD_DATA(LOAD_DATA), .ACCESS_FAULT(ACCESS_FAULT),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_BYTE_EN(DM_BYTE_EN), .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    fall_cyc, rise_cyc;
  string cur_tag = "init";

  // ack_at: ACCESS cycle (1-based) in which DM_ACK is driven; 0 = never.
  typedef struct {
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          ack_at;
    bit          ill, fault;
    logic [31:0] load, daddr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          busy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", cur_tag, name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %b, expected %b", cur_tag, name, act, exp);
    end
  endtask

  // Reference model: expected outcome of one request from the ISA rules.
  function automatic vec_t model(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int ack_at);
    vec_t        v;
    int          off;
    bit          legal, aligned, timed_out;
    logic [31:0] sh, b, h;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.ack_at = ack_at;
    off = int'(addr % 4);
    if (rd && !wr)      legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else if (wr && !rd) legal = f3 inside {3'd0, 3'd1, 3'd2};
    else                legal = 1'b0;
    if (f3[1:0] == 2'd1)      aligned = (addr % 2) == 0;
    else if (f3[1:0] == 2'd2) aligned = off == 0;
    else                      aligned = 1'b1;
    v.ill   = !(legal && aligned);
    v.fault = v.ill;
    v.load  = 32'd0;
    v.daddr = addr - 32'(off);
    v.be    = 4'hF;
    v.wd    = wdata;
    v.busy  = 0;
    if (!v.ill) begin
      if (wr) begin
        if (f3[1:0] == 2'd0) begin
          v.be = 4'(1 << off);
          v.wd = (wdata & 32'hFF) * 32'h01010101;
        end else if (f3[1:0] == 2'd1) begin
          v.be = 4'(3 << off);
          v.wd = (wdata & 32'hFFFF) * 32'h00010001;
        end
      end
      timed_out = (ack_at < 1) || (ack_at > TO);
      v.busy    = 1 + (timed_out ? TO : ack_at);
      v.fault   = timed_out;
      if (rd && !timed_out) begin
        sh = rdata >> (8 * off);
        b  = sh & 32'hFF;
        h  = sh & 32'hFFFF;
        case (f3)
          3'd0:    v.load = (b >= 128) ? b - 32'd256 : b;
          3'd4:    v.load = b;
          3'd1:    v.load = (h >= 32768) ? h - 32'd65536 : h;
          3'd5:    v.load = h;
          default: v.load = rdata;
        endcase
      end
    end
    return v;
  endfunction

  // Entered just after a rising edge with the DUT in IDLE; returns the same
  // way, with the request withdrawn.
  task automatic run_vec(input vec_t v);
    int n, busy_cnt;
    bit req_ok, done;
    MEM_READ = v.rd; MEM_WRITE = v.wr; FUNC3 = v.f3;
    ADDRESS = v.addr; WRITE_DATA = v.wdata;
    DM_ACK = 1'($urandom_range(0, 1));   // must be ignored in IDLE
    DM_RDATA = $urandom;
    #1;
    if (v.ill) begin
      chk1("ill_fault", ACCESS_FAULT, 1'b1);
      chk1("ill_busy", BUSY_WAIT, 1'b0);
      chk("ill_load", LOAD_DATA, 32'd0);
      @(posedge CLK); #1;
      chk1("ill_req", DM_REQ, 1'b0);
      chk1("ill_fault2", ACCESS_FAULT, 1'b1);
      MEM_READ = 0; MEM_WRITE = 0; DM_ACK = 0;
      #1;
      chk1("ill_clear", ACCESS_FAULT, 1'b0);
      return;
    end
    chk1("req_busy", BUSY_WAIT, 1'b1);
    chk1("req_fault", ACCESS_FAULT, 1'b0);
    busy_cnt = 1; n = 0; done = 0; req_ok = 1;
    while (!done && n <= TO + 1) begin
      @(posedge CLK); #1;
      if (BUSY_WAIT) begin
        n++;
        busy_cnt++;
        req_ok &= DM_REQ;
        if (n == 1) begin
          rise_cyc = cyc;
          chk("addr", DM_ADDR, v.daddr);
          chk("be", 32'(DM_BYTE_EN), 32'(v.be));
          chk1("we", DM_WE, v.wr);
          if (v.wr) chk("wdata", DM_WDATA, v.wd);
        end
        DM_ACK   = (n == v.ack_at);
        DM_RDATA = (n == v.ack_at) ? v.rdata : $urandom;
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.bound: got busy after %0d cycles, expected completion", cur_tag, n);
      MEM_READ = 0; MEM_WRITE = 0; DM_ACK = 0;
      return;
    end
    fall_cyc = cyc;
    DM_ACK = 1'($urandom_range(0, 1));   // must be ignored in COMPLETE
    #1;
    chk1("cmp_req", DM_REQ, 1'b0);
    chk("cmp_load", LOAD_DATA, v.load);
    chk1("cmp_fault", ACCESS_FAULT, v.fault);
    chk("busy_cycles", 32'(busy_cnt), 32'(v.busy));
    chk1("req_held", req_ok, 1'b1);
    @(posedge CLK); #1;
    MEM_READ = 0; MEM_WRITE = 0; DM_ACK = 0;
    #1;
    chk("idle_load", LOAD_DATA, 32'd0);
    chk1("idle_fault", ACCESS_FAULT, 1'b0);
    chk1("idle_busy", BUSY_WAIT, 1'b0);
  endtask

  vec_t tbl[14];

  initial begin
    vec_t v;
    int   f0;
    bit   rd, wr;
    logic [2:0] f3;

    tbl[0]  = '{1,0,3'b000,32'h1003,32'h0,32'h80000000,1, 0,0,32'hFFFFFF80,32'h1000,4'hF,32'h0,2};
    tbl[1]  = '{1,0,3'b100,32'h1003,32'h0,32'h80000000,1, 0,0,32'h00000080,32'h1000,4'hF,32'h0,2};
    tbl[2]  = '{0,1,3'b001,32'h2002,32'h1234ABCD,32'h0,5, 0,0,32'h0,32'h2000,4'hC,32'hABCDABCD,6};
    tbl[3]  = '{1,0,3'b010,32'h3001,32'h0,32'h0,1, 1,1,32'h0,32'h0,4'h0,32'h0,0};
    tbl[4]  = '{1,0,3'b011,32'h40,32'h0,32'h0,1, 1,1,32'h0,32'h0,4'h0,32'h0,0};
    tbl[5]  = '{1,1,3'b010,32'h40,32'h0,32'h0,1, 1,1,32'h0,32'h0,4'h0,32'h0,0};
    tbl[6]  = '{1,0,3'b010,32'h44,32'h0,32'hDEADBEEF,0, 0,1,32'h0,32'h44,4'hF,32'h0,9};
    tbl[7]  = '{1,0,3'b010,32'h48,32'h0,32'hDEADBEEF,8, 0,0,32'hDEADBEEF,32'h48,4'hF,32'h0,9};
    tbl[8]  = '{0,1,3'b000,32'h101,32'h000077A5,32'h0,1, 0,0,32'h0,32'h100,4'h2,32'hA5A5A5A5,2};
    tbl[9]  = '{1,0,3'b001,32'h2,32'h0,32'h80010000,2, 0,0,32'hFFFF8001,32'h0,4'hF,32'h0,3};
    tbl[10] = '{0,1,3'b100,32'h200,32'h11,32'h0,1, 1,1,32'h0,32'h0,4'h0,32'h0,0};
    tbl[11] = '{0,1,3'b001,32'h2003,32'h11,32'h0,1, 1,1,32'h0,32'h0,4'h0,32'h0,0};
    tbl[12] = '{1,0,3'b101,32'h6,32'h0,32'h80011234,3, 0,0,32'h00008001,32'h4,4'hF,32'h0,4};
    tbl[13] = '{1,0,3'b000,32'h21,32'h0,32'h00007F00,1, 0,0,32'h0000007F,32'h20,4'hF,32'h0,2};

    RST = 1; MEM_READ = 0; MEM_WRITE = 0; FUNC3 = 0; ADDRESS = 0;
    WRITE_DATA = 0; DM_RDATA = 0; DM_ACK = 0;
    repeat (2) @(posedge CLK);
    #1;
    cur_tag = "reset";
    chk1("busy", BUSY_WAIT, 1'b0);
    chk("load", LOAD_DATA, 32'd0);
    chk1("fault", ACCESS_FAULT, 1'b0);
    chk1("req", DM_REQ, 1'b0);
    chk1("we", DM_WE, 1'b0);
    chk("addr", DM_ADDR, 32'd0);
    chk("wdata", DM_WDATA, 32'd0);
    chk("be", 32'(DM_BYTE_EN), 32'd0);
    RST = 0;
    @(posedge CLK); #1;

    for (int i = 0; i < 14; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_vec(tbl[i]);
    end

    // Back-to-back: SW then LHU with immediate acks
    cur_tag = "b2b_sw";
    run_vec(model(0, 1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 1));
    f0 = fall_cyc;
    cur_tag = "b2b_lhu";
    v = model(1, 0, 3'b101, 32'h12, 32'h0, 32'hBEEF0000, 1);
    chk("model_check", v.load, 32'h0000BEEF);
    run_vec(v);
    chk("gap", 32'(rise_cyc - f0), 32'd2);

    // Reset in the middle of an outstanding access
    cur_tag = "rst_mid";
    MEM_READ = 1; FUNC3 = 3'b010; ADDRESS = 32'h100; DM_ACK = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk1("req_before", DM_REQ, 1'b1);
    #2;
    RST = 1; MEM_READ = 0;
    #1;
    chk1("req_async", DM_REQ, 1'b0);
    chk1("busy", BUSY_WAIT, 1'b0);
    chk("load", LOAD_DATA, 32'd0);
    @(posedge CLK); #1;
    RST = 0; DM_ACK = 1; DM_RDATA = 32'hFFFFFFFF;
    @(posedge CLK); #1;
    DM_ACK = 0;
    chk1("late_ack_req", DM_REQ, 1'b0);
    chk("late_ack_load", LOAD_DATA, 32'd0);
    @(posedge CLK); #1;
    chk("after_load", LOAD_DATA, 32'd0);
    chk1("after_fault", ACCESS_FAULT, 1'b0);

    // Randomized requests against the reference model
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:             begin rd = 1; wr = 1; end
        1, 2, 3, 4, 5: begin rd = 1; wr = 0; end
        default:       begin rd = 0; wr = 1; end
      endcase
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else case ($urandom_range(0, 4))
        0:       f3 = 3'b000;
        1:       f3 = 3'b001;
        2:       f3 = 3'b010;
        3:       f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      cur_tag = $sformatf("rnd%0d", i);
      run_vec(model(rd, wr, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 10))));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
